// File: rtl/i2c_target.sv
// I2C target responder with a register-pointer interface to a local register file.
// A write transaction loads the pointer from its first data byte and then writes
// the following bytes with pointer auto-increment. A read streams register bytes
// back, also auto-incrementing.
//
// Ports:
//   clock     system clock (at least 20x the SCL rate)
//   reset     asynchronous active-low reset
//   sda_read  raw SDA line level (synchronized internally)
//   scl_read  raw SCL line level (synchronized internally)
//   sda_out   SDA drive: 0 pulls low, 1 releases
//   reg_addr  current register pointer
//   wr_data   write byte, valid while wr_en is high
//   wr_en     one-cycle write strobe
//   rd_req    one-cycle read request for reg_addr
//   rd_data   register contents, valid the cycle after rd_req
//   busy      high from a matched address until STOP or an address mismatch
module i2c_target #(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned DRIVE_DELAY = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sda_read,
  input  logic       scl_read,
  output logic       sda_out,
  output logic [7:0] reg_addr,
  output logic [7:0] wr_data,
  output logic       wr_en,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  localparam int unsigned DlyW = (DRIVE_DELAY < 2) ? 1 : $clog2(DRIVE_DELAY + 1);
  localparam logic [DlyW-1:0] DlyLoad = DlyW'((DRIVE_DELAY == 0) ? 0 : DRIVE_DELAY - 1);

  typedef enum logic [3:0] {
    StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
    StWdata, StWdataAck, StRdata, StRack, StWaitStop
  } state_e;

  // Line synchronizers and previous synchronized values for edge detection
  logic sda_s1_q, sda_s2_q, scl_s1_q, scl_s2_q, sda_prev_q, scl_prev_q;

  state_e          state_q, state_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            byte_full_q, byte_full_d;
  logic            ack_on_q, ack_on_d;
  logic [7:0]      tx_q, tx_d;
  logic            rd_latch_q, rd_latch_d;
  logic            pend_q, pend_d;
  logic            pend_val_q, pend_val_d;
  logic [DlyW-1:0] dly_q, dly_d;
  logic            sda_out_q, sda_out_d;
  logic [7:0]      reg_addr_q, reg_addr_d;
  logic [7:0]      wr_data_q, wr_data_d;
  logic            wr_en_q, wr_en_d;
  logic            rd_req_q, rd_req_d;
  logic            busy_q, busy_d;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] byte_in;
  logic       sched, sched_val;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign start_det = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
  assign stop_det  = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
  assign byte_in   = {shift_q[6:0], sda_s2_q};

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    byte_full_d = byte_full_q;
    ack_on_d    = ack_on_q;
    tx_d        = tx_q;
    rd_latch_d  = rd_req_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    dly_d       = dly_q;
    sda_out_d   = sda_out_q;
    reg_addr_d  = reg_addr_q;
    wr_data_d   = wr_data_q;
    wr_en_d     = 1'b0;
    rd_req_d    = 1'b0;
    busy_d      = busy_q;
    sched       = 1'b0;
    sched_val   = 1'b1;

    // Register file answers one cycle after rd_req
    if (rd_latch_q) tx_d = rd_data;

    // Delayed SDA update: holds data for DRIVE_DELAY cycles after SCL falls
    if (pend_q) begin
      if (dly_q == '0) begin
        sda_out_d = pend_val_q;
        pend_d    = 1'b0;
      end else begin
        dly_d = dly_q - DlyW'(1);
      end
    end

    if (start_det || stop_det) begin
      state_d     = start_det ? StAddr : StIdle;
      bit_cnt_d   = '0;
      byte_full_d = 1'b0;
      ack_on_d    = 1'b0;
      pend_d      = 1'b0;
      sda_out_d   = 1'b1;
      if (stop_det) busy_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StWaitStop: ;
        StAddr: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              // General call (7'h00) is never acknowledged
              if (byte_in[7:1] == DEV_ADDR && byte_in[7:1] != 7'h00) begin
                state_d  = StAddrAck;
                busy_d   = 1'b1;
                ack_on_d = 1'b0;
              end else begin
                state_d = StWaitStop;
                busy_d  = 1'b0;
              end
            end
          end
        end
        StAddrAck: begin
          // shift_q[0] still holds the R/W bit of the address byte
          if (scl_fall) begin
            if (!ack_on_q) begin
              sched     = 1'b1;
              sched_val = 1'b0;
              ack_on_d  = 1'b1;
            end else begin
              ack_on_d  = 1'b0;
              bit_cnt_d = '0;
              sched     = 1'b1;
              if (shift_q[0]) begin
                state_d   = StRdata;
                sched_val = tx_q[7];
              end else begin
                state_d   = StPtr;
                sched_val = 1'b1;
              end
            end
          end else if (scl_rise && ack_on_q && shift_q[0]) begin
            rd_req_d = 1'b1;
          end
        end
        StPtr, StWdata: begin
          if (scl_rise) begin
            shift_d   = byte_in;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d = '0;
              ack_on_d  = 1'b0;
              if (state_q == StPtr) begin
                state_d = StPtrAck;
              end else begin
                state_d   = StWdataAck;
                wr_data_d = byte_in;
                wr_en_d   = 1'b1;
              end
            end
          end
        end
        StPtrAck, StWdataAck: begin
          if (scl_fall) begin
            sched = 1'b1;
            if (!ack_on_q) begin
              sched_val = 1'b0;
              ack_on_d  = 1'b1;
              if (state_q == StPtrAck) reg_addr_d = shift_q;
            end else begin
              sched_val = 1'b1;
              ack_on_d  = 1'b0;
              state_d   = StWdata;
              if (state_q == StWdataAck) reg_addr_d = reg_addr_q + 8'd1;
            end
          end
        end
        StRdata: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              bit_cnt_d   = '0;
              byte_full_d = 1'b1;
            end
          end else if (scl_fall) begin
            sched = 1'b1;
            if (byte_full_q) begin
              byte_full_d = 1'b0;
              sched_val   = 1'b1;
              reg_addr_d  = reg_addr_q + 8'd1;
              state_d     = StRack;
            end else begin
              // ~bit_cnt_q selects bit 7 down to 0 as the count advances
              sched_val = tx_q[~bit_cnt_q];
            end
          end
        end
        StRack: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              rd_req_d  = 1'b1;
              bit_cnt_d = '0;
              state_d   = StRdata;
            end else begin
              state_d = StWaitStop;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    if (sched) begin
      pend_d     = 1'b1;
      pend_val_d = sched_val;
      dly_d      = DlyLoad;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
      scl_s1_q    <= 1'b1;
      scl_s2_q    <= 1'b1;
      sda_prev_q  <= 1'b1;
      scl_prev_q  <= 1'b1;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      byte_full_q <= 1'b0;
      ack_on_q    <= 1'b0;
      tx_q        <= '0;
      rd_latch_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_val_q  <= 1'b1;
      dly_q       <= '0;
      sda_out_q   <= 1'b1;
      reg_addr_q  <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      rd_req_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sda_s1_q    <= sda_read;
      sda_s2_q    <= sda_s1_q;
      scl_s1_q    <= scl_read;
      scl_s2_q    <= scl_s1_q;
      sda_prev_q  <= sda_s2_q;
      scl_prev_q  <= scl_s2_q;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      byte_full_q <= byte_full_d;
      ack_on_q    <= ack_on_d;
      tx_q        <= tx_d;
      rd_latch_q  <= rd_latch_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      dly_q       <= dly_d;
      sda_out_q   <= sda_out_d;
      reg_addr_q  <= reg_addr_d;
      wr_data_q   <= wr_data_d;
      wr_en_q     <= wr_en_d;
      rd_req_q    <= rd_req_d;
      busy_q      <= busy_d;
    end
  end

  assign sda_out  = sda_out_q;
  assign reg_addr = reg_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;
  assign rd_req   = rd_req_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: a bit-banged I2C master on an open-drain line
// model, a small register file model, and monitors for the strobe outputs.
module tb_i2c_target;

  localparam int Q = 16;  // clock cycles per quarter SCL period

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       m_sda = 1'b1;
  logic       m_scl = 1'b1;
  logic       sda_line;
  logic       sda_out;
  logic [7:0] reg_addr;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       rd_req;
  logic [7:0] rd_data = 8'h00;
  logic       busy;

  int tests = 0;
  int fails = 0;

  logic [7:0] mem [0:255];
  logic [7:0] wr_addr_log [0:15];
  logic [7:0] wr_data_log [0:15];
  int wr_cnt = 0;
  int rd_cnt = 0;
  int both_cnt = 0;
  int long_cnt = 0;
  int low_cnt = 0;
  logic wr_prev = 1'b0;
  logic rd_prev = 1'b0;

  assign sda_line = m_sda & sda_out;

  always #5 clock = ~clock;

  i2c_target dut (
    .clock    (clock),
    .reset    (reset),
    .sda_read (sda_line),
    .scl_read (m_scl),
    .sda_out  (sda_out),
    .reg_addr (reg_addr),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  // Register file: data valid the cycle after rd_req
  always @(posedge clock) begin
    if (rd_req) rd_data <= mem[reg_addr];
  end

  always @(negedge clock) begin
    if (wr_en) begin
      if (wr_cnt < 16) begin
        wr_addr_log[wr_cnt] = reg_addr;
        wr_data_log[wr_cnt] = wr_data;
      end
      wr_cnt++;
    end
    if (rd_req) rd_cnt++;
    if (wr_en && rd_req) both_cnt++;
    if ((wr_en && wr_prev) || (rd_req && rd_prev)) long_cnt++;
    if (!sda_out) low_cnt++;
    wr_prev = wr_en;
    rd_prev = rd_req;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clock);
  endtask

  task automatic bit_cycle(input logic b, output logic s);
    m_sda = b;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    s = sda_line;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_sda = 1'b1;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0;
    wait_q();
    m_scl = 1'b1;
    wait_q();
    m_sda = 1'b1;
    wait_q();
    wait_q();
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_cycle(b[i], s);
    bit_cycle(1'b1, ack);
  endtask

  task automatic recv_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_cycle(1'b1, s);
      b[i] = s;
    end
    bit_cycle(ack, s);
  endtask

  initial begin
    logic       ack;
    logic       s;
    logic [7:0] rx;
    int         base;
    int         rd_base;
    int         bound;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h11] = 8'hC3;

    // Reset values
    repeat (4) @(negedge clock);
    check("rst_sda_out", 32'(sda_out), 32'h1);
    check("rst_reg_addr", 32'(reg_addr), 32'h00);
    check("rst_wr_data", 32'(wr_data), 32'h00);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_rd_req", 32'(rd_req), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    repeat (8) @(negedge clock);

    // Write burst
    base = wr_cnt;
    i2c_start();
    send_byte(8'h34, ack);
    check("wr_addr_ack", 32'(ack), 32'h0);
    check("wr_busy_on", 32'(busy), 32'h1);
    send_byte(8'h05, ack);
    check("wr_ptr_ack", 32'(ack), 32'h0);
    send_byte(8'hA5, ack);
    check("wr_d0_ack", 32'(ack), 32'h0);
    send_byte(8'h3C, ack);
    check("wr_d1_ack", 32'(ack), 32'h0);
    i2c_stop();
    check("wr_count", 32'(wr_cnt - base), 32'd2);
    check("wr0_addr", 32'(wr_addr_log[base]), 32'h05);
    check("wr0_data", 32'(wr_data_log[base]), 32'hA5);
    check("wr1_addr", 32'(wr_addr_log[base + 1]), 32'h06);
    check("wr1_data", 32'(wr_data_log[base + 1]), 32'h3C);
    check("wr_final_ptr", 32'(reg_addr), 32'h07);
    check("wr_busy_off", 32'(busy), 32'h0);

    // Address mismatch
    base = wr_cnt;
    low_cnt = 0;
    i2c_start();
    send_byte(8'h36, ack);
    check("mm_addr_nack", 32'(ack), 32'h1);
    check("mm_busy", 32'(busy), 32'h0);
    send_byte(8'h05, ack);
    check("mm_data_nack", 32'(ack), 32'h1);
    i2c_stop();
    check("mm_sda_low_cycles", 32'(low_cnt), 32'd0);
    check("mm_wr_count", 32'(wr_cnt - base), 32'd0);

    // Read with repeated START
    rd_base = rd_cnt;
    i2c_start();
    send_byte(8'h34, ack);
    check("rd_waddr_ack", 32'(ack), 32'h0);
    send_byte(8'h10, ack);
    check("rd_ptr_ack", 32'(ack), 32'h0);
    i2c_start();
    send_byte(8'h35, ack);
    check("rd_raddr_ack", 32'(ack), 32'h0);
    check("rd_busy", 32'(busy), 32'h1);
    recv_byte(1'b0, rx);
    check("rd_byte0", 32'(rx), 32'h5A);
    recv_byte(1'b1, rx);
    check("rd_byte1", 32'(rx), 32'hC3);
    check("rd_sda_released", 32'(sda_out), 32'h1);
    i2c_stop();
    check("rd_final_ptr", 32'(reg_addr), 32'h12);
    check("rd_req_count", 32'(rd_cnt - rd_base), 32'd2);
    check("rd_busy_off", 32'(busy), 32'h0);

    // Pointer wrap
    base = wr_cnt;
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'hFF, ack);
    send_byte(8'h11, ack);
    send_byte(8'h22, ack);
    check("wrap_last_ack", 32'(ack), 32'h0);
    i2c_stop();
    check("wrap_count", 32'(wr_cnt - base), 32'd2);
    check("wrap0_addr", 32'(wr_addr_log[base]), 32'hFF);
    check("wrap0_data", 32'(wr_data_log[base]), 32'h11);
    check("wrap1_addr", 32'(wr_addr_log[base + 1]), 32'h00);
    check("wrap1_data", 32'(wr_data_log[base + 1]), 32'h22);
    check("wrap_final_ptr", 32'(reg_addr), 32'h01);

    // STOP in the middle of a data byte
    base = wr_cnt;
    i2c_start();
    send_byte(8'h34, ack);
    send_byte(8'h05, ack);
    bit_cycle(1'b1, s);
    bit_cycle(1'b0, s);
    bit_cycle(1'b1, s);
    bit_cycle(1'b0, s);
    i2c_stop();
    check("pstop_wr_count", 32'(wr_cnt - base), 32'd0);
    check("pstop_ptr", 32'(reg_addr), 32'h05);
    check("pstop_busy", 32'(busy), 32'h0);
    check("pstop_sda", 32'(sda_out), 32'h1);

    // Reset while the address ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_cycle(((8'h34 >> i) & 8'h01) != 0, s);
    m_sda = 1'b1;
    bound = 0;
    while (sda_out !== 1'b0 && bound < 64) begin
      @(negedge clock);
      bound++;
    end
    check("rack_ack_driven", 32'(sda_out), 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("rack_async_release", 32'(sda_out), 32'h1);
    check("rack_async_busy", 32'(busy), 32'h0);
    m_scl = 1'b1;
    m_sda = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b1;
    repeat (8) @(negedge clock);
    check("rack_ptr_cleared", 32'(reg_addr), 32'h00);
    i2c_start();
    send_byte(8'h34, ack);
    check("rack_new_ack", 32'(ack), 32'h0);
    i2c_stop();
    check("rack_busy_off", 32'(busy), 32'h0);

    // Strobe hygiene across the whole run
    check("strobe_overlap", 32'(both_cnt), 32'd0);
    check("strobe_width", 32'(long_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
I2C target (slave) responder for the audio synthesizer control bus. It is the far end of the existing I2C master. It decodes START, STOP and repeated START, matches a 7-bit device address and exposes an 8-bit register-pointer interface to a local register file. Writes store a register pointer, then data bytes with pointer auto-increment. Reads stream register bytes back to the master, also with auto-increment.

Parameters:
DEV_ADDR, 7'h1A, 7-bit device address this target acknowledges
DRIVE_DELAY, 4, clock cycles after a detected SCL falling edge before sda_out changes (data hold)

Ports:
clock  input  1  system clock (≥ 20x SCL rate)
reset  input  1  asynchronous, active-low reset (0 = reset)
sda_read  input  1  sampled SDA line level
scl_read  input  1  sampled SCL line level
sda_out  output  1  SDA drive: 0 = pull low, 1 = release
reg_addr  output  8  current register pointer
wr_data  output  8  byte to write, valid while wr_en=1
wr_en  output  1  one-cycle write strobe
rd_req  output  1  one-cycle read request for register reg_addr
rd_data  input  8  register contents, valid the cycle after rd_req
busy  output  1  1 from matched address ACK until STOP or address mismatch

Behaviour:
- Reset (asynchronous, reset=0) values: sda_out=1, reg_addr=0, wr_data=0, wr_en=0, rd_req=0, busy=0, state=IDLE. Synchronizers are preset to 1.
- Reset asserted mid-transfer releases SDA in the same instant; it does not wait for a clock edge.
- sda_read and scl_read each pass through a 2-flop synchronizer. Edges are detected from the synchronized values.
- START: synchronized SDA falls while SCL=1. STOP: SDA rises while SCL=1.
- Bits are sampled on the SCL rising edge. sda_out changes DRIVE_DELAY cycles after the SCL falling edge.
- Bit counter is 3 bits and is cleared on START and at the end of each byte.
- START, including repeated START, from any state: go to ADDR, release SDA, bit counter=0. reg_addr is kept.
- STOP from any state: go to IDLE, release SDA, busy=0. A partial byte is discarded and no wr_en fires.
- States:
  - IDLE: wait for START.
  - ADDR: shift in 8 bits MSB first. After the 8th bit:
    - Address match: go to ADDR_ACK, busy=1.
    - Mismatch: go to WAIT_STOP and never drive SDA.
  - ADDR_ACK: drive 0 for one SCL period.
    - R/W=0: go to PTR.
    - R/W=1: pulse rd_req during ACK, latch rd_data the next clock, go to RDATA.
  - PTR: receive 8 bits. At the 8th SCL falling edge, load reg_addr, then PTR_ACK (drive 0). Next state is WDATA.
  - WDATA: receive 8 bits. At the 8th rising edge: wr_data=byte, wr_en=1 for one clock, then WDATA_ACK (drive 0). reg_addr increments by 1 at the end of the ACK. Wrap-around: 8'hFF -> 8'h00.
  - RDATA: sda_out takes latched bit 7..0, each changed DRIVE_DELAY cycles after the SCL falling edge. The first bit is driven after the ACK clock ends. After the 8th bit, release SDA, increment reg_addr (with wrap), go to RACK.
  - RACK: sample master on the rising edge.
    - 0 (ACK): pulse rd_req, latch rd_data, go to RDATA.
    - 1 (NACK): go to WAIT_STOP.
  - WAIT_STOP: SDA released. Leave only on STOP or START.
- ACK release: SDA is released DRIVE_DELAY cycles after the SCL falling edge that ends the ACK clock, unless RDATA drives the first data bit at that moment.
- wr_en and rd_req are never asserted together and never for more than one clock.
- SCL held low by the master for any duration keeps the state unchanged. There is no timeout.
- General-call address 7'h00 is treated as a mismatch.

Test Plan:
- Write burst: S, 0x34, 0x05, 0xA5, 0x3C, P -> sda_out=0 in the four ACK slots. wr_en pulses twice: (reg_addr 0x05, wr_data 0xA5) then (0x06, 0x3C). Final reg_addr=0x07, busy=0 after P.
- Address mismatch: S, 0x36, 0x05, P -> sda_out stays 1 throughout, no wr_en, busy stays 0.
- Read with repeated START: S, 0x34, 0x10, Sr, 0x35. The register model returns 0x5A@0x10 and 0xC3@0x11. Master ACKs the first byte and NACKs the second, then P -> bytes on SDA are 0x5A then 0xC3. SDA is released after the NACK, reg_addr=0x12, rd_req pulsed exactly twice.
- Pointer wrap: write pointer 0xFF, data 0x11, 0x22 -> writes land at 0xFF and then 0x00.
- STOP mid-byte: S, 0x34, 0x05, then 4 bits of data, then P -> no wr_en, state IDLE, reg_addr=0x05.
- Reset mid-ACK: assert reset while sda_out=0 in ADDR_ACK -> sda_out=1 immediately, without a clock edge. After release, a new S, 0x34 is ACKed normally.
